apb_completer_regs: RTL and testbench
=====================================

Name: apb_completer_regs

Overview:
APB completer: the responder end of the team's APB bus. It decodes APB transfers into a small 8-bit register bank, inserts a configurable number of wait states, and flags errors via PSLVERR. The DATA register also drives `data_out` to the rest of the design. The block sits behind the APB bus as its first mapped peripheral.

Parameters:
ADDR_WIDTH, 8, PADDR width in bits.
DATA_WIDTH, 8, PWDATA/PRDATA and register width; fixed at 8 for this revision.
WAIT_STATES, 1, PREADY-low cycles in each ACCESS phase; legal range 0-15.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  asynchronous, active-high reset.
psel  input  1  completer select.
penable  input  1  access-phase strobe.
pwrite  input  1  1 = write, 0 = read.
paddr  input  ADDR_WIDTH  byte address.
pwdata  input  DATA_WIDTH  write data.
prdata  output  DATA_WIDTH  read data; valid only while pready=1.
pready  output  1  transfer-complete strobe.
pslverr  output  1  error response; valid only while pready=1.
data_out  output  DATA_WIDTH  current DATA register value.

Behaviour:
- Reset (asynchronous, immediate):
  - FSM goes to IDLE; wait counter = 0.
  - pready = 0, pslverr = 0, prdata = 0x00.
  - CTRL = 0x00, DATA = 0x00, WCOUNT = 0x00, SCRATCH = 0xA5; data_out = 0x00.
- Register map (paddr):
  - 0x00 CTRL: RW.
  - 0x04 DATA: RW; drives data_out.
  - 0x08 WCOUNT: RO; count of successful writes, wraps 0xFF -> 0x00.
  - 0x0C SCRATCH: RW.
- Error conditions (pslverr = 1):
  - paddr[1:0] != 0.
  - Any address above 0x0C.
  - Any write to 0x08.
  - Error transfers change no register and do not increment WCOUNT; read data is 0x00.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE -> SETUP when psel=1 and penable=0.
  - SETUP -> ACCESS on the next edge if psel=1 and penable=1; otherwise -> IDLE (aborted, no side effects).
  - ACCESS: wait counter runs from WAIT_STATES down to 0 with pready=0.
  - When the counter is 0, pready=1 for exactly one cycle, then -> IDLE.
  - A back-to-back SETUP in the cycle after pready returns via IDLE -> SETUP; minimum transfer is 2+WAIT_STATES cycles.
- Completion cycle:
  - prdata, pslverr and pready are registered outputs, asserted together in the completion cycle.
  - All three return to 0 the following cycle.
  - Writes commit at the end of the completion cycle; data_out reflects a DATA write one cycle after pready.
  - A read of WCOUNT in the same transfer as nothing else returns the pre-transfer value.
- Address/data latching: paddr, pwrite and pwdata are latched on SETUP -> ACCESS. Changes during wait states are ignored.
- Protocol errors:
  - psel dropping during ACCESS aborts to IDLE: no commit, no pready.
  - penable=1 while in IDLE is ignored.
- Reset asserted mid-transfer: the transfer is discarded and the register bank is restored to its reset values.

Decomposition:
- Package apb_pkg:
  - FSM state enum (IDLE/SETUP/ACCESS).
  - Register offset constants ADDR_CTRL/ADDR_DATA/ADDR_WCOUNT/ADDR_SCRATCH.
  - SCRATCH_RESET = 8'hA5.
- One natural sub-module, apb_reg_bank: holds the four registers and handles decode and error generation. It takes latched address, write flag, write data and a commit strobe; it returns read data and an error flag.
- The FSM and wait counter stay in the top level.

Test Plan:
- Reset check: assert reset for 2 cycles, then read 0x0C. Expect prdata = 0xA5, pslverr = 0, and data_out = 0x00 throughout.
- Write/read DATA, WAIT_STATES=1:
  - Write 0x42 to 0x04: pready goes high exactly 3 cycles after SETUP; data_out = 0x42 one cycle later.
  - Read 0x04: returns 0x42.
  - Read 0x08: returns 0x01.
- Error responses:
  - Write 0x55 to 0x08: pslverr = 1 and WCOUNT unchanged.
  - Read 0x10: pslverr = 1, prdata = 0x00.
  - Read 0x05: pslverr = 1.
- WCOUNT wrap: perform 256 successful writes to 0x0C, then read 0x08. Expect 0x00.
- Abort cases:
  - Drop psel during a wait state of a write 0xFF to 0x04: no pready; data_out keeps its prior value.
  - Assert reset mid-ACCESS of a write to 0x00: CTRL reads back 0x00.
- Parameter sweep, WAIT_STATES=0 and 15:
  - Back-to-back writes 0x05, 0x0A, 0xFF to 0x04, each preceded by its own SETUP.
  - pready latency is 2 and 17 cycles respectively.
  - Final data_out = 0xFF; WCOUNT = 0x03.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and register map for the APB completer
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_DATA     = 8'h04;
  localparam logic [7:0] ADDR_WCOUNT   = 8'h08;
  localparam logic [7:0] ADDR_SCRATCH  = 8'h0C;

  localparam logic [7:0] SCRATCH_RESET = 8'hA5;

endpackage

// File: rtl/apb_reg_bank.sv
// rtl/apb_reg_bank.sv - register bank with address decode and error flagging
module apb_reg_bank
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_commit,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_wcount;
  logic [DATA_WIDTH-1:0] r_scratch;

  logic w_misaligned;
  logic w_out_of_range;
  logic w_ro_write;

  assign w_misaligned   = |i_addr[1:0];
  assign w_out_of_range = i_addr > ADDR_WIDTH'(ADDR_SCRATCH);
  assign w_ro_write     = i_write && (i_addr == ADDR_WIDTH'(ADDR_WCOUNT));
  assign o_err          = w_misaligned || w_out_of_range || w_ro_write;
  assign o_data         = r_data;

  // Error transfers always read back zero.
  always_comb begin
    o_rdata = '0;
    if (!o_err) begin
      case (i_addr)
        ADDR_WIDTH'(ADDR_CTRL):    o_rdata = r_ctrl;
        ADDR_WIDTH'(ADDR_DATA):    o_rdata = r_data;
        ADDR_WIDTH'(ADDR_WCOUNT):  o_rdata = r_wcount;
        ADDR_WIDTH'(ADDR_SCRATCH): o_rdata = r_scratch;
        default:                   o_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ctrl    <= '0;
      r_data    <= '0;
      r_wcount  <= '0;
      r_scratch <= DATA_WIDTH'(SCRATCH_RESET);
    end else if (i_commit && i_write && !o_err) begin
      case (i_addr)
        ADDR_WIDTH'(ADDR_CTRL):    r_ctrl    <= i_wdata;
        ADDR_WIDTH'(ADDR_DATA):    r_data    <= i_wdata;
        ADDR_WIDTH'(ADDR_SCRATCH): r_scratch <= i_wdata;
        default: ;
      endcase
      r_wcount <= r_wcount + DATA_WIDTH'(1);
    end
  end

endmodule

// File: rtl/apb_completer_regs.sv
// rtl/apb_completer_regs.sv - APB completer FSM with wait states over apb_reg_bank
module apb_completer_regs
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  apb_state_t            r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata;

  logic                  w_latch;
  logic                  w_commit;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic                  w_write;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_err;

  assign w_latch  = (r_state == SETUP) && psel && penable;
  assign w_commit = (r_state == ACCESS) && r_pready;
  // With zero wait states the response is built on the latching edge itself.
  assign w_addr   = w_latch ? paddr  : r_addr;
  assign w_write  = w_latch ? pwrite : r_write;

  apb_reg_bank #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bank (
    .i_clk   (clk),
    .i_reset (reset),
    .i_addr  (w_addr),
    .i_write (w_write),
    .i_wdata (r_wdata),
    .i_commit(w_commit),
    .o_rdata (w_rdata),
    .o_err   (w_err),
    .o_data  (data_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      case (r_state)
        IDLE: begin
          if (psel && !penable) r_state <= SETUP;
        end
        SETUP: begin
          if (w_latch) begin
            r_state <= ACCESS;
            r_addr  <= paddr;
            r_write <= pwrite;
            r_wdata <= pwdata;
            r_cnt   <= WAIT_INIT;
            if (WAIT_INIT == 4'd0) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_write ? '0 : w_rdata;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          if (r_pready) begin
            r_state <= IDLE;
          end else if (!psel) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_err;
              r_prdata  <= w_write ? '0 : w_rdata;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pready  = r_pready;
  assign pslverr = r_pslverr;
  assign prdata  = r_prdata;

endmodule

// File: tb/tb_apb_completer_regs.sv
// tb/tb_apb_completer_regs.sv - directed vectors for apb_completer_regs at WAIT_STATES 1, 0 and 15
module tb_apb_completer_regs;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       penable = 1'b0;
  logic       pwrite = 1'b0;
  logic [2:0] psel_v = 3'b000;
  logic [7:0] paddr = 8'h00;
  logic [7:0] pwdata = 8'h00;

  logic [2:0] pready_v;
  logic [2:0] pslverr_v;
  logic [7:0] prdata_v [3];
  logic [7:0] data_out_v [3];

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  apb_completer_regs #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
    .pslverr(pslverr_v[0]), .data_out(data_out_v[0])
  );

  apb_completer_regs #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
    .pslverr(pslverr_v[1]), .data_out(data_out_v[1])
  );

  apb_completer_regs #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_STATES(15)) u_ws15 (
    .clk(clk), .reset(reset), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
    .pslverr(pslverr_v[2]), .data_out(data_out_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Full transfer on instance k; returns at #1 after the edge that ends the completion cycle.
  task automatic xfer(input int k, input logic wr, input logic [7:0] a, input logic [7:0] d,
                      output logic [7:0] rd, output logic er, output int lat,
                      output logic [7:0] dout_rdy);
    psel_v    = 3'b000;
    psel_v[k] = 1'b1;
    penable   = 1'b0;
    pwrite    = wr;
    paddr     = a;
    pwdata    = d;
    lat       = 0;
    @(posedge clk); #1;
    lat     = 1;
    penable = 1'b1;
    while (!pready_v[k] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd       = prdata_v[k];
    er       = pslverr_v[k];
    dout_rdy = data_out_v[k];
    if (!pready_v[k]) chk("pready_timeout", {31'b0, pready_v[k]}, 32'd1);
    @(posedge clk); #1;
    psel_v  = 3'b000;
    penable = 1'b0;
  endtask

  task automatic do_read(input int k, input logic [7:0] a, input logic [7:0] exp_d,
                         input logic exp_e, input string tag);
    logic [7:0] rd, dr;
    logic       er;
    int         lat;
    xfer(k, 1'b0, a, 8'h00, rd, er, lat, dr);
    chk({tag, "_rdata"}, rd, exp_d);
    chk({tag, "_err"}, er, exp_e);
  endtask

  task automatic do_write(input int k, input logic [7:0] a, input logic [7:0] d,
                          input logic exp_e, input string tag);
    logic [7:0] rd, dr;
    logic       er;
    int         lat;
    xfer(k, 1'b1, a, d, rd, er, lat, dr);
    chk({tag, "_err"}, er, exp_e);
  endtask

  // Drive SETUP and the first ACCESS cycle of a write, leaving instance 0 in its wait state.
  task automatic start_write_ws1(input logic [7:0] a, input logic [7:0] d);
    psel_v  = 3'b001;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = a;
    pwdata  = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd, dr;
    logic       er, seen;
    int         lat;
    logic [7:0] sweep_d [3];
    sweep_d[0] = 8'h05;
    sweep_d[1] = 8'h0A;
    sweep_d[2] = 8'hFF;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_pready%0d", k), {31'b0, pready_v[k]}, 32'd0);
      chk($sformatf("rst_pslverr%0d", k), {31'b0, pslverr_v[k]}, 32'd0);
      chk($sformatf("rst_prdata%0d", k), prdata_v[k], 8'h00);
      chk($sformatf("rst_data_out%0d", k), data_out_v[k], 8'h00);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    xfer(0, 1'b0, 8'h0C, 8'h00, rd, er, lat, dr);
    chk("rst_scratch", rd, 8'hA5);
    chk("rst_scratch_err", er, 1'b0);
    chk("rst_scratch_lat", lat, 3);
    chk("rst_data_out_after", data_out_v[0], 8'h00);

    xfer(0, 1'b1, 8'h04, 8'h42, rd, er, lat, dr);
    chk("wr_data_lat", lat, 3);
    chk("wr_data_err", er, 1'b0);
    chk("wr_data_dout_at_ready", dr, 8'h00);
    chk("wr_data_dout_after", data_out_v[0], 8'h42);
    do_read(0, 8'h04, 8'h42, 1'b0, "rd_data");
    do_read(0, 8'h08, 8'h01, 1'b0, "rd_wcount1");

    do_write(0, 8'h08, 8'h55, 1'b1, "wr_wcount_ro");
    do_read(0, 8'h08, 8'h01, 1'b0, "rd_wcount_after_err");
    do_read(0, 8'h10, 8'h00, 1'b1, "rd_out_of_range");
    do_read(0, 8'h05, 8'h00, 1'b1, "rd_misaligned");

    // One earlier write plus 255 here takes WCOUNT past 0xFF back to 0x00.
    for (int i = 0; i < 255; i++) do_write(0, 8'h0C, 8'(i), 1'b0, "fill_scratch");
    do_read(0, 8'h0C, 8'hFE, 1'b0, "rd_scratch_last");
    do_read(0, 8'h08, 8'h00, 1'b0, "rd_wcount_wrap");

    start_write_ws1(8'h04, 8'hFF);
    psel_v  = 3'b000;
    penable = 1'b0;
    seen    = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | pready_v[0];
    end
    chk("abort_no_pready", seen, 1'b0);
    chk("abort_data_out", data_out_v[0], 8'h42);
    do_read(0, 8'h04, 8'h42, 1'b0, "abort_rd_data");
    do_read(0, 8'h08, 8'h00, 1'b0, "abort_rd_wcount");

    do_write(0, 8'h00, 8'h33, 1'b0, "wr_ctrl");
    do_read(0, 8'h00, 8'h33, 1'b0, "rd_ctrl");
    start_write_ws1(8'h00, 8'h77);
    reset = 1'b1;
    psel_v  = 3'b000;
    penable = 1'b0;
    @(posedge clk); #1;
    chk("midrst_pready", {31'b0, pready_v[0]}, 32'd0);
    chk("midrst_data_out", data_out_v[0], 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    do_read(0, 8'h00, 8'h00, 1'b0, "midrst_rd_ctrl");
    do_read(0, 8'h0C, 8'hA5, 1'b0, "midrst_rd_scratch");
    do_read(0, 8'h08, 8'h00, 1'b0, "midrst_rd_wcount");

    for (int k = 1; k < 3; k++) begin
      for (int j = 0; j < 3; j++) begin
        xfer(k, 1'b1, 8'h04, sweep_d[j], rd, er, lat, dr);
        chk($sformatf("sweep%0d_lat%0d", k, j), lat, (k == 1) ? 2 : 17);
        chk($sformatf("sweep%0d_err%0d", k, j), er, 1'b0);
      end
      chk($sformatf("sweep%0d_data_out", k), data_out_v[k], 8'hFF);
      do_read(k, 8'h08, 8'h03, 1'b0, $sformatf("sweep%0d_wcount", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
